// File: rtl/io_ring_pwr_seq.sv
// Supply-sequencing controller for the 1.8 V IO ring: synchronises and debounces
// the VDDIO/VDD supply-good detectors, then releases isolation and output enable.
module io_ring_pwr_seq #(
  parameter int CNT_W        = 16,
  parameter int DEBOUNCE_CYC = 64,
  parameter int SETTLE_CYC   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vddio_ok_async,
  input  logic       vdd_ok_async,
  input  logic       pwr_dn_req,
  input  logic       fault_clr,
  output logic       iso_en,
  output logic       pad_oe_en,
  output logic       ring_ready,
  output logic       fault,
  output logic [2:0] state
);

  localparam logic [2:0] S_WAIT   = 3'd0;
  localparam logic [2:0] S_DEISO  = 3'd1;
  localparam logic [2:0] S_ACTIVE = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_OFF    = 3'd4;

  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  logic [1:0]       vddio_sync;
  logic [1:0]       vdd_sync;
  logic             supply_ok;
  logic             loss_fault;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vddio_sync <= '0;
      vdd_sync   <= '0;
    end else begin
      vddio_sync <= {vddio_sync[0], vddio_ok_async};
      vdd_sync   <= {vdd_sync[0], vdd_ok_async};
    end
  end

  assign supply_ok = vddio_sync[1] & vdd_sync[1];

  // Losing a supply while the pads are not isolated is the only fault source.
  always_comb begin
    loss_fault = 1'b0;
    if (!supply_ok && (state == S_DEISO || state == S_ACTIVE || state == S_DRAIN))
      loss_fault = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_WAIT;
      cnt        <= '0;
      iso_en     <= 1'b1;
      pad_oe_en  <= 1'b0;
      ring_ready <= 1'b0;
      fault      <= 1'b0;
    end else begin
      fault <= loss_fault | (fault & ~fault_clr);
      if (loss_fault) begin
        state      <= S_WAIT;
        cnt        <= '0;
        iso_en     <= 1'b1;
        pad_oe_en  <= 1'b0;
        ring_ready <= 1'b0;
      end else begin
        case (state)
          S_WAIT: begin
            if (pwr_dn_req) begin
              state <= S_OFF;
              cnt   <= '0;
            end else if (!supply_ok) begin
              cnt <= '0;
            end else if (cnt == DEB_LAST) begin
              state  <= S_DEISO;
              iso_en <= 1'b0;
              cnt    <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_DEISO: begin
            if (pwr_dn_req) begin
              state  <= S_OFF;
              iso_en <= 1'b1;
              cnt    <= '0;
            end else if (cnt == SETTLE_LAST) begin
              state      <= S_ACTIVE;
              pad_oe_en  <= 1'b1;
              ring_ready <= 1'b1;
              cnt        <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_ACTIVE: begin
            if (pwr_dn_req) begin
              state      <= S_DRAIN;
              pad_oe_en  <= 1'b0;
              ring_ready <= 1'b0;
              cnt        <= '0;
            end
          end
          S_DRAIN: begin
            if (cnt == SETTLE_LAST) begin
              state  <= S_OFF;
              iso_en <= 1'b1;
              cnt    <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_OFF: begin
            iso_en     <= 1'b1;
            pad_oe_en  <= 1'b0;
            ring_ready <= 1'b0;
            if (!pwr_dn_req) begin
              state <= S_WAIT;
              cnt   <= '0;
            end
          end
          default: begin
            state      <= S_WAIT;
            cnt        <= '0;
            iso_en     <= 1'b1;
            pad_oe_en  <= 1'b0;
            ring_ready <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_io_ring_pwr_seq.sv
// Directed bench for io_ring_pwr_seq with DEBOUNCE_CYC=8, SETTLE_CYC=4.
// Cycle N means "just after posedge N"; raw inputs changed there are first sampled at N+1.
module tb_io_ring_pwr_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vddio_ok_async = 1'b0;
  logic       vdd_ok_async = 1'b0;
  logic       pwr_dn_req = 1'b0;
  logic       fault_clr = 1'b0;
  logic       iso_en;
  logic       pad_oe_en;
  logic       ring_ready;
  logic       fault;
  logic [2:0] state;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  io_ring_pwr_seq #(.CNT_W(16), .DEBOUNCE_CYC(8), .SETTLE_CYC(4)) dut (
    .clk(clk), .rst(rst), .vddio_ok_async(vddio_ok_async), .vdd_ok_async(vdd_ok_async),
    .pwr_dn_req(pwr_dn_req), .fault_clr(fault_clr), .iso_en(iso_en), .pad_oe_en(pad_oe_en),
    .ring_ready(ring_ready), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; vddio_ok_async = 1'b0; vdd_ok_async = 1'b0;
    pwr_dn_req = 1'b0; fault_clr = 1'b0;
    step(); step();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_checks++; if (iso_en !== 1'b1) $display("FAIL rst_iso: actual=%0d expected=1", iso_en); else n_pass++;
    n_checks++; if (pad_oe_en !== 1'b0) $display("FAIL rst_pad: actual=%0d expected=0", pad_oe_en); else n_pass++;
    n_checks++; if (ring_ready !== 1'b0) $display("FAIL rst_ready: actual=%0d expected=0", ring_ready); else n_pass++;
    n_checks++; if (fault !== 1'b0) $display("FAIL rst_fault: actual=%0d expected=0", fault); else n_pass++;
    n_checks++; if (state !== 3'd0) $display("FAIL rst_state: actual=%0d expected=0", state); else n_pass++;
  endtask

  task automatic test_release();
    do_reset();
    wait_to(10); vddio_ok_async = 1'b1; vdd_ok_async = 1'b1;
    wait_to(19);
    n_checks++; if (iso_en !== 1'b1) $display("FAIL rel_iso19: actual=%0d expected=1", iso_en); else n_pass++;
    n_checks++; if (state !== 3'd0) $display("FAIL rel_state19: actual=%0d expected=0", state); else n_pass++;
    wait_to(20);
    n_checks++; if (iso_en !== 1'b0) $display("FAIL rel_iso20: actual=%0d expected=0", iso_en); else n_pass++;
    n_checks++; if (state !== 3'd1) $display("FAIL rel_state20: actual=%0d expected=1", state); else n_pass++;
    wait_to(23);
    n_checks++; if (pad_oe_en !== 1'b0) $display("FAIL rel_pad23: actual=%0d expected=0", pad_oe_en); else n_pass++;
    wait_to(24);
    n_checks++; if (pad_oe_en !== 1'b1) $display("FAIL rel_pad24: actual=%0d expected=1", pad_oe_en); else n_pass++;
    n_checks++; if (ring_ready !== 1'b1) $display("FAIL rel_ready24: actual=%0d expected=1", ring_ready); else n_pass++;
    n_checks++; if (state !== 3'd2) $display("FAIL rel_state24: actual=%0d expected=2", state); else n_pass++;
    n_checks++; if (fault !== 1'b0) $display("FAIL rel_fault24: actual=%0d expected=0", fault); else n_pass++;
  endtask

  task automatic test_debounce_restart();
    do_reset();
    vddio_ok_async = 1'b1; vdd_ok_async = 1'b1;
    wait_to(5); vdd_ok_async = 1'b0;
    wait_to(8); vdd_ok_async = 1'b1;
    wait_to(10);
    n_checks++; if (iso_en !== 1'b1) $display("FAIL deb_iso10: actual=%0d expected=1", iso_en); else n_pass++;
    wait_to(17);
    n_checks++; if (iso_en !== 1'b1) $display("FAIL deb_iso17: actual=%0d expected=1", iso_en); else n_pass++;
    n_checks++; if (state !== 3'd0) $display("FAIL deb_state17: actual=%0d expected=0", state); else n_pass++;
    wait_to(18);
    n_checks++; if (iso_en !== 1'b0) $display("FAIL deb_iso18: actual=%0d expected=0", iso_en); else n_pass++;
    n_checks++; if (state !== 3'd1) $display("FAIL deb_state18: actual=%0d expected=1", state); else n_pass++;
  endtask

  task automatic test_wait_pwr_dn();
    do_reset();
    vddio_ok_async = 1'b1; vdd_ok_async = 1'b1;
    wait_to(9); pwr_dn_req = 1'b1;
    wait_to(10);
    n_checks++; if (state !== 3'd4) $display("FAIL wdn_state10: actual=%0d expected=4", state); else n_pass++;
    n_checks++; if (iso_en !== 1'b1) $display("FAIL wdn_iso10: actual=%0d expected=1", iso_en); else n_pass++;
    wait_to(12);
    n_checks++; if (state !== 3'd4) $display("FAIL wdn_state12: actual=%0d expected=4", state); else n_pass++;
    pwr_dn_req = 1'b0;
    wait_to(13);
    n_checks++; if (state !== 3'd0) $display("FAIL wdn_state13: actual=%0d expected=0", state); else n_pass++;
    wait_to(22);
    n_checks++; if (state !== 3'd1) $display("FAIL deiso_dn_state22: actual=%0d expected=1", state); else n_pass++;
    n_checks++; if (iso_en !== 1'b0) $display("FAIL deiso_dn_iso22: actual=%0d expected=0", iso_en); else n_pass++;
    pwr_dn_req = 1'b1;
    wait_to(23);
    n_checks++; if (state !== 3'd4) $display("FAIL deiso_dn_state23: actual=%0d expected=4", state); else n_pass++;
    n_checks++; if (iso_en !== 1'b1) $display("FAIL deiso_dn_iso23: actual=%0d expected=1", iso_en); else n_pass++;
    pwr_dn_req = 1'b0;
  endtask

  task automatic test_power_down();
    do_reset();
    vddio_ok_async = 1'b1; vdd_ok_async = 1'b1;
    wait_to(14);
    n_checks++; if (state !== 3'd2) $display("FAIL pd_state14: actual=%0d expected=2", state); else n_pass++;
    wait_to(49);
    n_checks++; if (pad_oe_en !== 1'b1) $display("FAIL pd_pad49: actual=%0d expected=1", pad_oe_en); else n_pass++;
    pwr_dn_req = 1'b1;
    wait_to(50);
    n_checks++; if (pad_oe_en !== 1'b0) $display("FAIL pd_pad50: actual=%0d expected=0", pad_oe_en); else n_pass++;
    n_checks++; if (ring_ready !== 1'b0) $display("FAIL pd_ready50: actual=%0d expected=0", ring_ready); else n_pass++;
    n_checks++; if (state !== 3'd3) $display("FAIL pd_state50: actual=%0d expected=3", state); else n_pass++;
    wait_to(53);
    n_checks++; if (iso_en !== 1'b0) $display("FAIL pd_iso53: actual=%0d expected=0", iso_en); else n_pass++;
    wait_to(54);
    n_checks++; if (iso_en !== 1'b1) $display("FAIL pd_iso54: actual=%0d expected=1", iso_en); else n_pass++;
    n_checks++; if (state !== 3'd4) $display("FAIL pd_state54: actual=%0d expected=4", state); else n_pass++;
    wait_to(56); pwr_dn_req = 1'b0;
    wait_to(57);
    n_checks++; if (state !== 3'd0) $display("FAIL pd_state57: actual=%0d expected=0", state); else n_pass++;
    wait_to(64);
    n_checks++; if (iso_en !== 1'b1) $display("FAIL pd_iso64: actual=%0d expected=1", iso_en); else n_pass++;
    wait_to(65);
    n_checks++; if (iso_en !== 1'b0) $display("FAIL pd_iso65: actual=%0d expected=0", iso_en); else n_pass++;
    n_checks++; if (state !== 3'd1) $display("FAIL pd_state65: actual=%0d expected=1", state); else n_pass++;
  endtask

  task automatic test_supply_loss();
    do_reset();
    vddio_ok_async = 1'b1; vdd_ok_async = 1'b1;
    wait_to(60); vddio_ok_async = 1'b0;
    wait_to(62);
    n_checks++; if (pad_oe_en !== 1'b1) $display("FAIL loss_pad62: actual=%0d expected=1", pad_oe_en); else n_pass++;
    n_checks++; if (fault !== 1'b0) $display("FAIL loss_fault62: actual=%0d expected=0", fault); else n_pass++;
    wait_to(63);
    n_checks++; if (iso_en !== 1'b1) $display("FAIL loss_iso63: actual=%0d expected=1", iso_en); else n_pass++;
    n_checks++; if (pad_oe_en !== 1'b0) $display("FAIL loss_pad63: actual=%0d expected=0", pad_oe_en); else n_pass++;
    n_checks++; if (ring_ready !== 1'b0) $display("FAIL loss_ready63: actual=%0d expected=0", ring_ready); else n_pass++;
    n_checks++; if (fault !== 1'b1) $display("FAIL loss_fault63: actual=%0d expected=1", fault); else n_pass++;
    n_checks++; if (state !== 3'd0) $display("FAIL loss_state63: actual=%0d expected=0", state); else n_pass++;
    wait_to(64); fault_clr = 1'b1;
    wait_to(65); fault_clr = 1'b0;
    n_checks++; if (fault !== 1'b0) $display("FAIL clr_fault65: actual=%0d expected=0", fault); else n_pass++;
    vddio_ok_async = 1'b1;
    wait_to(79);
    n_checks++; if (state !== 3'd2) $display("FAIL reup_state79: actual=%0d expected=2", state); else n_pass++;
    n_checks++; if (fault !== 1'b0) $display("FAIL reup_fault79: actual=%0d expected=0", fault); else n_pass++;
    wait_to(80); vddio_ok_async = 1'b0;
    wait_to(82); fault_clr = 1'b1;
    wait_to(83); fault_clr = 1'b0;
    n_checks++; if (fault !== 1'b1) $display("FAIL setclr_fault83: actual=%0d expected=1", fault); else n_pass++;
    n_checks++; if (state !== 3'd0) $display("FAIL setclr_state83: actual=%0d expected=0", state); else n_pass++;
    wait_to(84);
    n_checks++; if (fault !== 1'b1) $display("FAIL setclr_fault84: actual=%0d expected=1", fault); else n_pass++;
  endtask

  task automatic test_loss_in_drain();
    do_reset();
    vddio_ok_async = 1'b1; vdd_ok_async = 1'b1;
    wait_to(19); pwr_dn_req = 1'b1;
    wait_to(20);
    n_checks++; if (state !== 3'd3) $display("FAIL drn_state20: actual=%0d expected=3", state); else n_pass++;
    wait_to(21); vdd_ok_async = 1'b0;
    wait_to(23);
    n_checks++; if (state !== 3'd3) $display("FAIL drn_state23: actual=%0d expected=3", state); else n_pass++;
    n_checks++; if (fault !== 1'b0) $display("FAIL drn_fault23: actual=%0d expected=0", fault); else n_pass++;
    wait_to(24);
    n_checks++; if (state !== 3'd0) $display("FAIL drn_state24: actual=%0d expected=0", state); else n_pass++;
    n_checks++; if (fault !== 1'b1) $display("FAIL drn_fault24: actual=%0d expected=1", fault); else n_pass++;
    n_checks++; if (iso_en !== 1'b1) $display("FAIL drn_iso24: actual=%0d expected=1", iso_en); else n_pass++;
    pwr_dn_req = 1'b0;
  endtask

  task automatic test_async_rst();
    do_reset();
    vddio_ok_async = 1'b1; vdd_ok_async = 1'b1;
    wait_to(12);
    n_checks++; if (state !== 3'd1) $display("FAIL arst_state12: actual=%0d expected=1", state); else n_pass++;
    #3 rst = 1'b1;
    #1;
    n_checks++; if (iso_en !== 1'b1) $display("FAIL arst_deiso_iso: actual=%0d expected=1", iso_en); else n_pass++;
    n_checks++; if (state !== 3'd0) $display("FAIL arst_deiso_state: actual=%0d expected=0", state); else n_pass++;
    step();
    rst = 1'b0;
    cyc = 0;
    wait_to(9);
    n_checks++; if (iso_en !== 1'b1) $display("FAIL arst_rdeb_iso9: actual=%0d expected=1", iso_en); else n_pass++;
    wait_to(10);
    n_checks++; if (iso_en !== 1'b0) $display("FAIL arst_rdeb_iso10: actual=%0d expected=0", iso_en); else n_pass++;
    wait_to(14);
    n_checks++; if (pad_oe_en !== 1'b1) $display("FAIL arst_pad14: actual=%0d expected=1", pad_oe_en); else n_pass++;
    #3 rst = 1'b1;
    #1;
    n_checks++; if (pad_oe_en !== 1'b0) $display("FAIL arst_act_pad: actual=%0d expected=0", pad_oe_en); else n_pass++;
    n_checks++; if (ring_ready !== 1'b0) $display("FAIL arst_act_ready: actual=%0d expected=0", ring_ready); else n_pass++;
    n_checks++; if (iso_en !== 1'b1) $display("FAIL arst_act_iso: actual=%0d expected=1", iso_en); else n_pass++;
    step();
    rst = 1'b0;
  endtask

  task automatic test_random_toggle();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      vddio_ok_async = ($urandom_range(0, 15) != 0);
      vdd_ok_async   = ($urandom_range(0, 15) != 0);
      pwr_dn_req     = ($urandom_range(0, 31) == 0);
      fault_clr      = ($urandom_range(0, 7) == 0);
      step();
      n_checks++; if (pad_oe_en && iso_en) $display("FAIL inv_oe_iso cyc%0d: pad_oe_en=%0d iso_en=%0d required iso_en=0", i, pad_oe_en, iso_en); else n_pass++;
      n_checks++; if (ring_ready !== pad_oe_en) $display("FAIL inv_ready cyc%0d: actual=%0d expected=%0d", i, ring_ready, pad_oe_en); else n_pass++;
    end
    vddio_ok_async = 1'b0; vdd_ok_async = 1'b0; pwr_dn_req = 1'b0; fault_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_release();
    test_debounce_restart();
    test_wait_pwr_dn();
    test_power_down();
    test_supply_loss();
    test_loss_in_drain();
    test_async_rst();
    test_random_toggle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/io_ring_pwr_seq.md
# io_ring_pwr_seq

Digital supply-sequencing controller for the GF22FDX 1.8 V IO ring. It sits at the core end of the ring's supply pads. It synchronises and debounces the analog supply-good detectors for VDDIO and VDD, then sequences pad isolation release and output enable. On supply loss or a software power-down request it drives the ring back to a safe, isolated state.

## Interface
Parameters:
- CNT_W, 16, width of the shared debounce/settle counter
- DEBOUNCE_CYC, 64, consecutive cycles both supplies must read good before isolation is released; legal range 1..2^CNT_W-1
- SETTLE_CYC, 16, cycles spent in each transition state (DEISO, DRAIN); legal range 1..2^CNT_W-1

Ports:
- clk  in  1  single block clock
- rst  in  1  asynchronous, active-high reset
- vddio_ok_async  in  1  raw VDDIO supply-good from detector; asynchronous to clk
- vdd_ok_async  in  1  raw core-supply-good; asynchronous to clk
- pwr_dn_req  in  1  synchronous level request to power the ring down
- fault_clr  in  1  synchronous single-cycle clear of the sticky fault flag
- iso_en  out  1  pad isolation enable; 1 = pads isolated/clamped
- pad_oe_en  out  1  global pad output-enable gate
- ring_ready  out  1  ring fully operational
- fault  out  1  sticky: supply lost while the ring was not isolated
- state  out  3  current FSM state encoding

## Operation
- Both async inputs pass through 2-flop synchronisers that reset to 0. supply_ok = vddio_ok_s & vdd_ok_s.
- All outputs are registered. Reset values: iso_en=1, pad_oe_en=0, ring_ready=0, fault=0, state=WAIT(0), counter=0.
- FSM states: WAIT=0, DEISO=1, ACTIVE=2, DRAIN=3, OFF=4. Other encodings go to WAIT with safe outputs.
- WAIT:
  - supply_ok=1: counter increments; supply_ok=0: counter clears.
  - When supply_ok=1 and counter==DEBOUNCE_CYC-1: go to DEISO, iso_en<=0, counter<=0.
  - pwr_dn_req=1: go to OFF. This takes priority over debounce completion.
- DEISO: counter counts SETTLE_CYC cycles, then go to ACTIVE with pad_oe_en<=1 and ring_ready<=1.
- ACTIVE: pwr_dn_req=1 → DRAIN, pad_oe_en<=0, ring_ready<=0, counter<=0.
- DRAIN: after SETTLE_CYC cycles, iso_en<=1 and go to OFF.
- OFF: iso_en=1, pad_oe_en=0. Hold while pwr_dn_req=1. pwr_dn_req=0 → WAIT with counter<=0 (full re-debounce).
- pwr_dn_req=1 in DEISO → OFF directly, iso_en<=1.
- Supply loss (supply_ok=0) in DEISO, ACTIVE or DRAIN:
  - Next edge: iso_en<=1, pad_oe_en<=0, ring_ready<=0, fault<=1, go to WAIT, counter<=0.
  - Supply loss has priority over pwr_dn_req and over counter expiry.
- Supply loss in WAIT or OFF: no fault. Counter clears (WAIT) or no action (OFF).
- fault clears on fault_clr=1. Simultaneous fault set and fault_clr: set wins.
- Invariant, checked every cycle: pad_oe_en=1 implies iso_en=0. ring_ready == pad_oe_en.

## Timing
- Sync latency: 2 cycles from a raw input change to supply_ok.
- Release timing, with raw inputs first sampled high at edge E0:
  - supply_ok is high from E2.
  - iso_en falls at edge E2+DEBOUNCE_CYC.
  - pad_oe_en and ring_ready rise SETTLE_CYC edges later.
- Power-down:
  - pwr_dn_req sampled high in ACTIVE at edge En: pad_oe_en falls at En.
  - iso_en rises at En+SETTLE_CYC.
- Supply loss:
  - Raw input low at edge Ek: safe outputs at Ek+3 (2 sync cycles + 1 register).
  - Glitch rule: a glitch shorter than one clock may be missed; any low seen by supply_ok restarts debounce.
- rst asserted mid-sequence: all outputs go immediately (asynchronously) to their reset values. Release gives a full re-debounce from WAIT.
- The state output reflects the registered state and has the same timing as the outputs.

## Test plan
- DEBOUNCE_CYC=8, SETTLE_CYC=4; both raw oks rise at cycle 10 → iso_en falls at cycle 20; pad_oe_en and ring_ready rise at 24; fault stays 0.
- vdd_ok drops for 3 cycles after 5 good debounce cycles → counter restarts; iso_en falls 8 cycles after supply_ok returns high.
- In ACTIVE, pwr_dn_req=1 at cycle 50 → pad_oe_en=0 at 50, iso_en=1 at 54, state=OFF. Release request → state WAIT, then full 8-cycle re-debounce.
- In ACTIVE, vddio_ok drops at cycle 60 → at 63 iso_en=1, pad_oe_en=0, fault=1, state=WAIT. fault_clr pulse → fault=0. Fault set coincident with fault_clr → fault=1.
- Supply loss in the same cycle as pwr_dn_req in DRAIN → fault=1, state=WAIT (loss has priority).
- rst pulsed in DEISO and in ACTIVE → outputs at reset values immediately. Invariant (pad_oe_en=1 implies iso_en=0) asserted throughout randomized supply toggling.
